attention_scheduler: RTL and testbench

Round-robin scheduler that shares one `attention_unit` among `NUM_REQ` token-stream requesters. It accepts one embedding vector at a time and issues it to the unit with a single-cycle `valid_in` pulse. It captures the unit's result and returns it tagged with the requester index. A watchdog recovers the unit if a result never arrives. It sits between the per-stream token buffers and the shared attention datapath; weight buses are wired directly to the unit and are not handled here.

---
 rtl/attention_scheduler_if.sv | 42 ++++
 rtl/attention_scheduler.sv | 143 ++++++++++++++
 tb/tb_attention_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/attention_scheduler_if.sv
// Purpose: bundles requester, attention-unit and response signals of the scheduler.
// Latency: none, wires only.
// Backpressure: req_ready grants one requester at a time; rsp_ready low stalls the response.
interface attention_scheduler_if #(
    parameter int NUM_REQ    = 4,
    parameter int EMBED_DIM  = 8,
    parameter int DATA_WIDTH = 16
);
    localparam int VEC_W = EMBED_DIM * DATA_WIDTH;
    localparam int ID_W  = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*VEC_W-1:0]   req_x;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       unit_rst;
    logic                       unit_valid_in;
    logic [VEC_W-1:0]           unit_x_in;
    logic                       unit_valid_out;
    logic [VEC_W-1:0]           unit_y_out;
    logic                       rsp_valid;
    logic [ID_W-1:0]            rsp_id;
    logic [VEC_W-1:0]           rsp_y;
    logic                       rsp_ready;
    logic                       err_timeout;
    logic [ID_W-1:0]            err_id;
    logic                       busy;
    logic [15:0]                done_count;

    // Scheduler side.
    modport slave (
        input  req_valid, req_x, unit_valid_out, unit_y_out, rsp_ready,
        output req_ready, unit_rst, unit_valid_in, unit_x_in, rsp_valid, rsp_id, rsp_y,
               err_timeout, err_id, busy, done_count
    );

    // Requesters, attention unit and response consumer.
    modport master (
        output req_valid, req_x, unit_valid_out, unit_y_out, rsp_ready,
        input  req_ready, unit_rst, unit_valid_in, unit_x_in, rsp_valid, rsp_id, rsp_y,
               err_timeout, err_id, busy, done_count
    );
endinterface

// File: rtl/attention_scheduler.sv
// Purpose: round-robin sharing of one attention unit among NUM_REQ requesters, with timeout recovery.
// Latency: grant at T, unit issue at T+1, response at T+7 for a 5-cycle unit; one job per 8 cycles.
// Backpressure: rsp_ready low holds RESP indefinitely and blocks new grants.
module attention_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int EMBED_DIM  = 8,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    attention_scheduler_if.slave  bus
);
    localparam int VEC_W = EMBED_DIM * DATA_WIDTH;
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_RECOVER
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    rr_nxt;
    logic [ID_W-1:0]    cur_id;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    cand;
    logic [ID_W:0]      sum;
    logic               grant_vld;
    logic               expire;
    logic [CNT_W-1:0]   wait_cnt;
    logic [VEC_W-1:0]   req_vec [NUM_REQ];
    logic [VEC_W-1:0]   x_reg;
    logic [VEC_W-1:0]   y_reg;
    logic [ID_W-1:0]    rsp_id_reg;
    logic [15:0]        done_cnt;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_vec[g] = bus.req_x[g*VEC_W +: VEC_W];
    end

    // Scan from rr_ptr upward; iterating offsets high-to-low lets the nearest requester win.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        sum       = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            cand = sum[ID_W-1:0];
            if (bus.req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
        end
    end

    assign rr_nxt = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A result landing on the final wait cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        expire    = 1'b0;
        case (state)
            S_IDLE:    if (grant_vld) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.unit_valid_out) begin
                    state_nxt = S_RESP;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    expire    = 1'b1;
                    state_nxt = S_RECOVER;
                end
            end
            S_RESP:    if (bus.rsp_ready) state_nxt = S_IDLE;
            S_RECOVER: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            cur_id     <= '0;
            wait_cnt   <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            rsp_id_reg <= '0;
            done_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        x_reg  <= req_vec[grant_id];
                        cur_id <= grant_id;
                        rr_ptr <= rr_nxt;
                    end
                end
                S_ISSUE: wait_cnt <= '0;
                S_WAIT: begin
                    if (bus.unit_valid_out) begin
                        y_reg      <= bus.unit_y_out;
                        rsp_id_reg <= cur_id;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) done_cnt <= done_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready     = (state == S_IDLE && grant_vld && !rst) ? (NUM_REQ'(1) << grant_id) : '0;
    assign bus.unit_rst      = rst | (state == S_RECOVER);
    assign bus.unit_valid_in = (state == S_ISSUE);
    assign bus.unit_x_in     = x_reg;
    assign bus.rsp_valid     = (state == S_RESP);
    assign bus.rsp_id        = rsp_id_reg;
    assign bus.rsp_y         = y_reg;
    assign bus.err_timeout   = expire & ~rst;
    assign bus.err_id        = cur_id;
    assign bus.busy          = (state != S_IDLE);
    assign bus.done_count    = done_cnt;
endmodule

// File: tb/tb_attention_scheduler.sv
// Purpose: directed self-checking bench for attention_scheduler with a behavioural attention unit.
// Latency: unit model answers unit_delay cycles after sampling unit_valid_in (0 = never).
// Backpressure: rsp_ready is driven per scenario to exercise stalls.
module tb_attention_scheduler;
    localparam int NR  = 4;
    localparam int ED  = 8;
    localparam int DW  = 16;
    localparam int TO  = 32;
    localparam int VW  = ED * DW;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   unit_delay;
    int   pend;
    logic stray;
    logic [VW-1:0] unit_y;

    attention_scheduler_if #(.NUM_REQ(NR), .EMBED_DIM(ED), .DATA_WIDTH(DW)) m ();

    attention_scheduler #(.NUM_REQ(NR), .EMBED_DIM(ED), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m.unit_rst) pend <= 0;
        else if (m.unit_valid_in && unit_delay > 0) pend <= unit_delay;
        else if (pend > 0) pend <= pend - 1;
    end

    always_comb begin
        m.unit_valid_out = (pend == 1) || stray;
        m.unit_y_out     = unit_y;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m.req_valid = '0;
        m.rsp_ready = 1'b1;
        stray = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m.req_valid = '1;
        tick();
        settle();
        checks++;
        if (m.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", m.req_ready); end
        checks++;
        if (m.unit_rst !== 1'b1) begin errors++; $display("FAIL reset_unit_rst: got %b want 1", m.unit_rst); end
        tick();
        rst = 1'b0;
        m.req_valid = '0;
        settle();
        checks++;
        if ({m.busy, m.rsp_valid, m.unit_valid_in, m.err_timeout, m.unit_rst} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {m.busy, m.rsp_valid, m.unit_valid_in, m.err_timeout, m.unit_rst});
        end
        checks++;
        if (m.unit_x_in !== '0 || m.rsp_y !== '0) begin errors++; $display("FAIL reset_vectors: x %h y %h want 0", m.unit_x_in, m.rsp_y); end
        checks++;
        if (m.rsp_id !== 2'd0 || m.err_id !== 2'd0 || m.done_count !== 16'd0) begin
            errors++; $display("FAIL reset_ids: rsp_id %0d err_id %0d done %0d want 0", m.rsp_id, m.err_id, m.done_count);
        end
    endtask

    task automatic test_single();
        logic [VW-1:0] x;
        logic [VW-1:0] y;
        x = {ED{16'h0100}};
        y = {ED{16'h0200}};
        unit_y = y;
        unit_delay = 5;
        m.rsp_ready = 1'b1;
        m.req_x = {{ED{16'hAAAA}}, x, {ED{16'hBBBB}}, {ED{16'hCCCC}}};
        m.req_valid = 4'b0100;
        settle();
        checks++;
        if (m.req_ready !== 4'b0100 || m.unit_valid_in !== 1'b0) begin
            errors++; $display("FAIL single_grant: ready %b vin %b want 0100 0", m.req_ready, m.unit_valid_in);
        end
        tick();
        m.req_valid = '0;
        settle();
        checks++;
        if (m.unit_valid_in !== 1'b1 || m.unit_x_in !== x) begin
            errors++; $display("FAIL single_issue: vin %b x %h want 1 %h", m.unit_valid_in, m.unit_x_in, x);
        end
        for (int k = 2; k <= 7; k++) begin
            tick();
            settle();
            checks++;
            if (k < 7) begin
                if ({m.unit_valid_in, m.rsp_valid} !== 2'b00) begin
                    errors++; $display("FAIL single_quiet_T%0d: vin/rsp %b want 00", k, {m.unit_valid_in, m.rsp_valid});
                end
            end else if (m.rsp_valid !== 1'b1 || m.rsp_id !== 2'd2 || m.rsp_y !== y) begin
                errors++; $display("FAIL single_rsp: valid %b id %0d y %h want 1 2 %h", m.rsp_valid, m.rsp_id, m.rsp_y, y);
            end
        end
        tick();
        settle();
        checks++;
        if (m.done_count !== 16'd1 || m.busy !== 1'b0) begin
            errors++; $display("FAIL single_done: count %0d busy %b want 1 0", m.done_count, m.busy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] gq[$];
        int         cq[$];
        logic [3:0] e;
        do_reset();
        unit_delay = 5;
        m.req_valid = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            settle();
            if (m.req_ready !== 4'b0000) begin
                gq.push_back(m.req_ready);
                cq.push_back(c);
            end
            tick();
        end
        m.req_valid = '0;
        checks++;
        if (gq.size() != 5) begin errors++; $display("FAIL rr_count: got %0d grants want 5", gq.size()); end
        for (int i = 0; i < gq.size() && i < 5; i++) begin
            e = 4'b0001 << (i % 4);
            checks++;
            if (gq[i] !== e || cq[i] != 8 * i) begin
                errors++; $display("FAIL rr_grant%0d: got %b at %0d want %b at %0d", i, gq[i], cq[i], e, 8 * i);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] y;
        do_reset();
        y = {ED{16'h1234}};
        unit_y = y;
        unit_delay = 5;
        m.rsp_ready = 1'b0;
        m.req_valid = 4'b0001;
        settle();
        tick();
        m.req_valid = 4'b1111;
        repeat (6) tick();
        for (int s = 0; s < 10; s++) begin
            settle();
            checks++;
            if (m.rsp_valid !== 1'b1 || m.rsp_id !== 2'd0 || m.rsp_y !== y || m.req_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_stall%0d: valid %b id %0d y %h ready %b", s, m.rsp_valid, m.rsp_id, m.rsp_y, m.req_ready);
            end
            tick();
        end
        m.rsp_ready = 1'b1;
        settle();
        checks++;
        if (m.rsp_valid !== 1'b1 || m.done_count !== 16'd0) begin
            errors++; $display("FAIL bp_accept: valid %b count %0d want 1 0", m.rsp_valid, m.done_count);
        end
        tick();
        settle();
        checks++;
        if (m.done_count !== 16'd1 || m.req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_after: count %0d ready %b want 1 0010", m.done_count, m.req_ready);
        end
        m.req_valid = '0;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        unit_delay = 0;
        m.rsp_ready = 1'b1;
        m.req_valid = 4'b0010;
        settle();
        checks++;
        if (m.req_ready !== 4'b0010) begin errors++; $display("FAIL to_grant: got %b want 0010", m.req_ready); end
        tick();
        m.req_valid = 4'b0100;
        for (int k = 1; k <= TO + 3; k++) begin
            settle();
            checks++;
            if (m.err_timeout !== (k == TO + 1)) begin
                errors++; $display("FAIL to_err_T%0d: got %b want %b", k, m.err_timeout, (k == TO + 1));
            end
            if (k == TO + 1) begin
                checks++;
                if (m.err_id !== 2'd1) begin errors++; $display("FAIL to_err_id: got %0d want 1", m.err_id); end
            end
            checks++;
            if (m.unit_rst !== (k == TO + 2)) begin
                errors++; $display("FAIL to_unit_rst_T%0d: got %b want %b", k, m.unit_rst, (k == TO + 2));
            end
            checks++;
            if (k <= TO + 2) begin
                if (m.rsp_valid !== 1'b0 || m.req_ready !== 4'b0000) begin
                    errors++; $display("FAIL to_quiet_T%0d: rsp %b ready %b want 0 0000", k, m.rsp_valid, m.req_ready);
                end
            end else if (m.req_ready !== 4'b0100 || m.rsp_valid !== 1'b0) begin
                errors++; $display("FAIL to_next_grant: ready %b rsp %b want 0100 0", m.req_ready, m.rsp_valid);
            end
            if (k == TO + 3) m.req_valid = '0;
            tick();
        end
        unit_delay = 5;
    endtask

    task automatic test_result_at_limit();
        logic [VW-1:0] y;
        do_reset();
        y = {ED{16'h0F0F}};
        unit_y = y;
        unit_delay = TO;
        m.rsp_ready = 1'b1;
        m.req_valid = 4'b1000;
        settle();
        tick();
        m.req_valid = '0;
        for (int k = 1; k <= TO + 3; k++) begin
            settle();
            checks++;
            if (m.err_timeout !== 1'b0) begin errors++; $display("FAIL lim_err_T%0d: got %b want 0", k, m.err_timeout); end
            if (k == TO + 2) begin
                checks++;
                if (m.rsp_valid !== 1'b1 || m.rsp_id !== 2'd3 || m.rsp_y !== y) begin
                    errors++; $display("FAIL lim_rsp: valid %b id %0d y %h want 1 3 %h", m.rsp_valid, m.rsp_id, m.rsp_y, y);
                end
            end
            if (k == TO + 3) begin
                checks++;
                if (m.done_count !== 16'd1 || m.busy !== 1'b0 || m.unit_rst !== 1'b0) begin
                    errors++; $display("FAIL lim_done: count %0d busy %b urst %b want 1 0 0", m.done_count, m.busy, m.unit_rst);
                end
            end
            tick();
        end
        unit_delay = 5;
    endtask

    task automatic test_reset_mid_wait();
        logic [VW-1:0] y;
        do_reset();
        y = {ED{16'h5555}};
        unit_y = y;
        unit_delay = 5;
        m.rsp_ready = 1'b1;
        m.req_x = {(NR*ED){16'h7777}};
        m.req_valid = 4'b0010;
        settle();
        tick();
        m.req_valid = '0;
        repeat (7) tick();
        settle();
        checks++;
        if (m.done_count !== 16'd1 || m.rsp_id !== 2'd1) begin
            errors++; $display("FAIL mid_pre: count %0d id %0d want 1 1", m.done_count, m.rsp_id);
        end
        m.req_valid = 4'b0010;
        tick();
        m.req_valid = '0;
        tick();
        tick();
        rst = 1'b1;
        settle();
        checks++;
        if (m.unit_rst !== 1'b1 || m.req_ready !== 4'b0000) begin
            errors++; $display("FAIL mid_rst_active: urst %b ready %b want 1 0000", m.unit_rst, m.req_ready);
        end
        tick();
        rst = 1'b0;
        stray = 1'b1;
        settle();
        checks++;
        if ({m.busy, m.rsp_valid, m.unit_valid_in, m.err_timeout} !== 4'b0 || m.unit_x_in !== '0 || m.rsp_y !== '0) begin
            errors++; $display("FAIL mid_outputs: flags %b x %h y %h want 0", {m.busy, m.rsp_valid, m.unit_valid_in, m.err_timeout}, m.unit_x_in, m.rsp_y);
        end
        checks++;
        if (m.done_count !== 16'd0 || m.rsp_id !== 2'd0 || m.err_id !== 2'd0) begin
            errors++; $display("FAIL mid_counts: count %0d id %0d err_id %0d want 0", m.done_count, m.rsp_id, m.err_id);
        end
        tick();
        stray = 1'b0;
        for (int k = 0; k < 6; k++) begin
            settle();
            checks++;
            if (m.rsp_valid !== 1'b0 || m.busy !== 1'b0) begin
                errors++; $display("FAIL mid_stray%0d: rsp %b busy %b want 0 0", k, m.rsp_valid, m.busy);
            end
            tick();
        end
        m.req_valid = 4'b1111;
        settle();
        checks++;
        if (m.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_next_grant: got %b want 0001", m.req_ready); end
        m.req_valid = '0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        m.req_valid = '0;
        m.req_x = '0;
        m.rsp_ready = 1'b1;
        unit_delay = 5;
        unit_y = '0;
        stray = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_result_at_limit();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
